// File: rtl/adder_pkg.sv
// Shared definitions for the adder family: word width and sequencer state encoding.
package adder_pkg;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} adder_seq_state_t;
endpackage

// File: rtl/adder_16.sv
// Single 16-bit ripple word adder; the sequencer reuses one instance for every word.
module adder_16 (
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, in1} + {1'b0, in2} + {16'b0, cin};
endmodule

// File: rtl/adder_wide_seq.sv
// Multi-precision adder sequencer: NUM_WORDS*16-bit a+b+cin, one word per cycle, LSW first.
// Optional feature macro ADDER_OVF_EN adds a registered signed-overflow output ovf.
module adder_wide_seq
  import adder_pkg::*;
#(
  parameter int NUM_WORDS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_WORDS*WORD_W-1:0] op_a,
  input  logic [NUM_WORDS*WORD_W-1:0] op_b,
  input  logic                        cin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_WORDS*WORD_W-1:0] sum,
  output logic                        cout
`ifdef ADDER_OVF_EN
  ,
  output logic                        ovf
`endif
);
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  adder_seq_state_t  state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic [WORD_W-1:0] a_q [NUM_WORDS];
  logic [WORD_W-1:0] a_d [NUM_WORDS];
  logic [WORD_W-1:0] b_q [NUM_WORDS];
  logic [WORD_W-1:0] b_d [NUM_WORDS];
  logic [WORD_W-1:0] sum_q [NUM_WORDS];
  logic [WORD_W-1:0] sum_d [NUM_WORDS];
`ifdef ADDER_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  logic [WORD_W-1:0] add_in1, add_in2, add_sum;
  logic              add_cout;

  assign add_in1 = a_q[idx_q];
  assign add_in2 = b_q[idx_q];

  adder_16 u_adder_16 (
    .in1  (add_in1),
    .in2  (add_in2),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
`ifdef ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int w = 0; w < NUM_WORDS; w++) begin
            a_d[w] = op_a[w*WORD_W +: WORD_W];
            b_d[w] = op_b[w*WORD_W +: WORD_W];
          end
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q] = add_sum;
        carry_d      = add_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout;
`ifdef ADDER_OVF_EN
          // Signed overflow: operands agree in sign but the MSW result does not.
          ovf_d   = (add_in1[WORD_W-1] == add_in2[WORD_W-1]) &&
                    (add_sum[WORD_W-1] != add_in1[WORD_W-1]);
`endif
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      for (int w = 0; w < NUM_WORDS; w++) sum_q[w] <= '0;
`ifdef ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      sum_q   <= sum_d;
`ifdef ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Operand holding registers carry no reset; they are only read after a capture.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign cout      = cout_q;
`ifdef ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_sum
    assign sum[w*WORD_W +: WORD_W] = sum_q[w];
  end
endmodule

// File: tb/tb_adder_wide_seq.sv
// Self-checking bench for adder_wide_seq (NUM_WORDS=4): directed table, corner sequences, random ops.
module tb_adder_wide_seq;
  localparam int NW = 4;
  localparam int W  = NW * 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef ADDER_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  adder_wide_seq #(.NUM_WORDS(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Reference: plain wide arithmetic on the whole operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    logic [W:0] t;
    logic       ov;
    t  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    ov = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return {ov, t};
  endfunction

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W-1:0] es, input logic eco,
                        input logic eov, input int hold);
    int   lat;
    logic busy_rdy;
    logic unstable;
    lat      = 0;
    busy_rdy = 1'b0;
    unstable = 1'b0;
    chk({tag, "/in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; op_a = a; op_b = b; cin = c;
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom}; cin = 1'b0;
    for (int k = 1; k <= NW + 4; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = k; break; end
      if (in_ready) busy_rdy = 1'b1;
    end
    chk({tag, "/latency"}, 64'(lat), 64'(NW));
    chk({tag, "/in_ready_run"}, 64'(busy_rdy), 64'd0);
    chk({tag, "/sum"}, sum, es);
    chk({tag, "/cout"}, 64'(cout), 64'(eco));
`ifdef ADDER_OVF_EN
    chk({tag, "/ovf"}, 64'(ovf), 64'(eov));
`else
    if (eov === 1'bx) $display("note: %s has unknown ovf expectation", tag);
`endif
    for (int k = 0; k < hold; k++) begin
      in_valid = k[0]; op_a = {$urandom, $urandom};
      @(posedge clk); #1;
      if (!out_valid || in_ready || sum !== es || cout !== eco) unstable = 1'b1;
    end
    if (hold > 0) chk({tag, "/held_stable"}, 64'(unstable), 64'd0);
    in_valid = 1'b0;
    chk({tag, "/in_ready_done"}, 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "/out_valid_clear"}, 64'(out_valid), 64'd0);
    chk({tag, "/sum_held_idle"}, sum, es);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           hold;
  } vec_t;

  vec_t vt [9];

  initial begin
    logic [W+1:0] m;
    logic [W-1:0] ra, rb;
    logic         rc;

    vt[0] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 0};
    vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 0};
    vt[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 64'h1, 1'b1, 1'b0, 0};
    vt[3] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0};
    vt[4] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 64'h0, 1'b1, 1'b0, 0};
    vt[5] = '{64'hDA83_DA83_DA83_DA83, 64'h43AF_43AF_43AF_43AF, 1'b0,
              64'h1E33_1E33_1E33_1E32, 1'b1, 1'b0, 10};
    vt[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 0};
    vt[7] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
              64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0};
    vt[8] = '{64'h1, 64'h1, 1'b0, 64'h2, 1'b0, 1'b0, 2};

    rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/in_ready", 64'(in_ready), 64'd0);
    chk("reset/out_valid", 64'(out_valid), 64'd0);
    chk("reset/sum", sum, 64'd0);
    chk("reset/cout", 64'(cout), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].c, vt[i].s, vt[i].co, vt[i].ov,
             vt[i].hold);

    // Reset asserted for one edge while word 2 is being added.
    in_valid = 1'b1; op_a = 64'h1234_1234_1234_1234; op_b = 64'h1111_1111_1111_1111; cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midreset/out_valid", 64'(out_valid), 64'd0);
    chk("midreset/sum", sum, 64'd0);
    chk("midreset/cout", 64'(cout), 64'd0);
    chk("midreset/in_ready_low", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("midreset/in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("midreset/no_result", 64'(out_valid), 64'd0);
    run_op("after_reset", 64'h1, 64'h1, 1'b1, 64'h3, 1'b0, 1'b0, 0);

    // out_ready while idle must not disturb anything.
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_out_ready/out_valid", 64'(out_valid), 64'd0);
    chk("idle_out_ready/sum", sum, 64'h3);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: begin ra = '1; rb = {$urandom, $urandom}; end
        1: begin ra = {$urandom, $urandom}; rb = ~ra; end
        default: begin ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; end
      endcase
      rc = 1'($urandom_range(0, 1));
      m  = model(ra, rb, rc);
      run_op($sformatf("rand%0d", i), ra, rb, rc, m[W-1:0], m[W], m[W+1],
             int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end
endmodule
